// File: rtl/xgemac_rtl_pkg.sv
// Shared types and constants for the XGE MAC TX-side blocks.
package xgemac_rtl_pkg;

  localparam int XGE_DATA_W = 64;
  localparam int XGE_MOD_W  = 3;

  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t;

  typedef enum logic {ST_IDLE, ST_LOCKED} mux_state_t;

endpackage

// File: rtl/xgemac_rr_arbiter.sv
// Packet arbiter: one-hot grant plus index. In round-robin mode the search
// starts just after the last winner; in fixed mode channel 0 always leads.
module xgemac_rr_arbiter
  import xgemac_rtl_pkg::*;
#(
  parameter int        NUM_CH   = 4,
  parameter arb_mode_t ARB_MODE = ARB_RR,
  localparam int       IDX_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              upd,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic [IDX_W-1:0] ptr;

  // Scan from the far end back to the start so the earliest match in search order wins
  always_comb begin
    int start;
    int j;
    gnt     = '0;
    gnt_idx = '0;
    start   = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr);
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = start + k;
      if (j >= NUM_CH) j -= NUM_CH;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  // Move the search start past the winner on every packet grant
  always_ff @(posedge clk) begin
    if (!rst_n)   ptr <= '0;
    else if (upd) ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/xgemac_tx_pkt_mux.sv
// N-channel packet mux in front of the MAC pkt_tx port. A channel owns the
// output from SOP to EOP; orphan beats seen while idle are drained and counted.
module xgemac_tx_pkt_mux
  import xgemac_rtl_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  DATA_W   = XGE_DATA_W,
  parameter int  ARB_MODE = 0,
  parameter int  CNT_W    = 16,
  localparam int MOD_W    = XGE_MOD_W,
  localparam int IDX_W    = $clog2(NUM_CH)
) (
  input  logic                     clk_156m25,
  input  logic                     reset_156m25_n,
  input  logic [NUM_CH-1:0]        ch_val,
  input  logic [NUM_CH-1:0]        ch_sop,
  input  logic [NUM_CH-1:0]        ch_eop,
  input  logic [NUM_CH*MOD_W-1:0]  ch_mod,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_rdy,
  output logic                     pkt_tx_val,
  output logic                     pkt_tx_sop,
  output logic                     pkt_tx_eop,
  output logic [MOD_W-1:0]         pkt_tx_mod,
  output logic [DATA_W-1:0]        pkt_tx_data,
  input  logic                     pkt_tx_full,
  output logic [NUM_CH*CNT_W-1:0]  pkt_cnt,
  output logic [NUM_CH*CNT_W-1:0]  err_cnt,
  output logic [IDX_W-1:0]         cur_ch
);

  localparam arb_mode_t MODE = (ARB_MODE != 0) ? ARB_FIXED : ARB_RR;

  mux_state_t        state;
  logic [NUM_CH-1:0] req, orphan, gnt, cur_oh, pkt_inc, err_inc;
  logic [IDX_W-1:0]  gnt_idx, sel;
  logic              idle, grant, fwd;

  assign idle   = (state == ST_IDLE);
  assign req    = ch_val & ch_sop;
  assign orphan = ch_val & ~ch_sop;
  assign grant  = idle & (|req) & ~pkt_tx_full;
  assign cur_oh = NUM_CH'(1) << cur_ch;
  assign sel    = idle ? gnt_idx : cur_ch;
  assign fwd    = idle ? grant : (ch_val[cur_ch] & ~pkt_tx_full);

  xgemac_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (MODE)
  ) u_arb (
    .clk     (clk_156m25),
    .rst_n   (reset_156m25_n),
    .req     (req),
    .upd     (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Idle: drain orphans and take the winner's SOP; locked: only the owner; full stalls all
  always_comb begin
    ch_rdy = '0;
    if (!pkt_tx_full) ch_rdy = idle ? (orphan | gnt) : cur_oh;
  end

  // Statistics events for the accepted beat(s) of this cycle
  always_comb begin
    pkt_inc = '0;
    err_inc = '0;
    if (idle) begin
      if (!pkt_tx_full) err_inc = orphan;
      if (grant)        pkt_inc = gnt & ch_eop;
    end else if (fwd) begin
      pkt_inc = cur_oh & ch_eop;
      err_inc = cur_oh & ch_sop;
    end
  end

  // Packet lock FSM with the single registered output stage; mid-packet SOP is masked
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state       <= ST_IDLE;
      cur_ch      <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      pkt_tx_data <= '0;
    end else begin
      pkt_tx_val <= fwd;
      pkt_tx_sop <= fwd & idle;
      pkt_tx_eop <= fwd & ch_eop[sel];
      if (fwd) begin
        pkt_tx_mod  <= ch_mod[int'(sel)*MOD_W +: MOD_W];
        pkt_tx_data <= ch_data[int'(sel)*DATA_W +: DATA_W];
      end
      case (state)
        ST_IDLE: if (grant) begin
          cur_ch <= gnt_idx;
          if (!ch_eop[gnt_idx]) state <= ST_LOCKED;
        end
        ST_LOCKED: if (fwd && ch_eop[cur_ch]) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    logic [CNT_W-1:0] pc, ec;

    // Saturating per-channel packet and error counters
    always_ff @(posedge clk_156m25) begin
      if (!reset_156m25_n) begin
        pc <= '0;
        ec <= '0;
      end else begin
        if (pkt_inc[i] && pc != {CNT_W{1'b1}}) pc <= pc + 1'b1;
        if (err_inc[i] && ec != {CNT_W{1'b1}}) ec <= ec + 1'b1;
      end
    end

    assign pkt_cnt[i*CNT_W +: CNT_W] = pc;
    assign err_cnt[i*CNT_W +: CNT_W] = ec;
  end

endmodule

// File: tb/tb_xgemac_tx_pkt_mux.sv
// Bench for xgemac_tx_pkt_mux: RR instance (CNT_W=4) and fixed-priority instance
// share stimulus; per-channel source queues, expected-beat scoreboard.
`timescale 1ns/1ps
module tb_xgemac_tx_pkt_mux;
  localparam int N = 4;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    logic [3:0] val;
    logic [3:0] sop;
    logic       full;
    logic [3:0] rdy;
    string      nm;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   ch_val, ch_sop, ch_eop;
  logic [11:0]  ch_mod;
  logic [255:0] ch_data;
  logic         full;

  logic [3:0]  rdy_a, rdy_b;
  logic        val_a, sop_a, eop_a, val_b, sop_b, eop_b;
  logic [2:0]  mod_a, mod_b;
  logic [63:0] data_a, data_b;
  logic [15:0] pkt_cnt_a, err_cnt_a;
  logic [63:0] pkt_cnt_b, err_cnt_b;
  logic [1:0]  cur_a, cur_b;

  always #5 clk = ~clk;

  xgemac_tx_pkt_mux #(.NUM_CH(4), .DATA_W(64), .ARB_MODE(0), .CNT_W(4)) dut_a (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .ch_val(ch_val), .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_mod(ch_mod), .ch_data(ch_data),
    .ch_rdy(rdy_a), .pkt_tx_val(val_a), .pkt_tx_sop(sop_a), .pkt_tx_eop(eop_a),
    .pkt_tx_mod(mod_a), .pkt_tx_data(data_a), .pkt_tx_full(full),
    .pkt_cnt(pkt_cnt_a), .err_cnt(err_cnt_a), .cur_ch(cur_a));

  xgemac_tx_pkt_mux #(.NUM_CH(4), .DATA_W(64), .ARB_MODE(1), .CNT_W(16)) dut_b (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .ch_val(ch_val), .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_mod(ch_mod), .ch_data(ch_data),
    .ch_rdy(rdy_b), .pkt_tx_val(val_b), .pkt_tx_sop(sop_b), .pkt_tx_eop(eop_b),
    .pkt_tx_mod(mod_b), .pkt_tx_data(data_b), .pkt_tx_full(full),
    .pkt_cnt(pkt_cnt_b), .err_cnt(err_cnt_b), .cur_ch(cur_b));

  int    n_chk = 0, n_err = 0;
  beat_t exp_q[$];
  beat_t src_q[N][$];
  bit    use_b = 1'b0;
  int    cyc = 0, first_cyc = -1, last_cyc = -1, n_beats = 0;
  vec_t  vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic new_meas();
    first_cyc = -1; last_cyc = -1; n_beats = 0;
  endtask

  // Check one MAC output cycle against the head of the scoreboard
  task automatic mon();
    logic v, s, e; logic [2:0] m; logic [63:0] d; beat_t x;
    if (use_b) begin v = val_b; s = sop_b; e = eop_b; m = mod_b; d = data_b; end
    else       begin v = val_a; s = sop_a; e = eop_a; m = mod_a; d = data_a; end
    cyc++;
    if (v) begin
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      n_beats++;
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", d);
      end else begin
        x = exp_q.pop_front();
        chk("beat_data", d, x.data);
        chk("beat_ctl", 64'({s, e, m}), 64'({x.sop, x.eop, x.mod}));
      end
    end
  endtask

  task automatic load_pkt(input int ch, input int id, input int nb, input logic [2:0] mod, input bit to_exp);
    beat_t x;
    for (int b = 0; b < nb; b++) begin
      x.sop  = (b == 0);
      x.eop  = (b == nb - 1);
      x.mod  = (b == nb - 1) ? mod : 3'd0;
      x.data = {8'(ch), 16'(id), 8'(b), 32'hC0FFEE00};
      src_q[ch].push_back(x);
      if (to_exp) exp_q.push_back(x);
    end
  endtask

  task automatic drive();
    beat_t x;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        x = src_q[i][0];
        ch_val[i] = 1'b1; ch_sop[i] = x.sop; ch_eop[i] = x.eop;
        ch_mod[i*3 +: 3] = x.mod; ch_data[i*64 +: 64] = x.data;
      end else begin
        ch_val[i] = 1'b0; ch_sop[i] = 1'b0; ch_eop[i] = 1'b0;
      end
    end
  endtask

  function automatic bit src_busy();
    bit b = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic clear_src();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  // One clock: sample handshake and output at negedge, then advance sources
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = ch_val & (use_b ? rdy_b : rdy_a);
    mon();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((exp_q.size() > 0 || src_busy()) && k < maxc) begin step(); k++; end
    repeat (2) step();
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; full = 1'b0;
    clear_src(); drive(); exp_q.delete();
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_val"},  64'(val_a), 64'd0);
    chk({tag, "_sop"},  64'(sop_a), 64'd0);
    chk({tag, "_eop"},  64'(eop_a), 64'd0);
    chk({tag, "_mod"},  64'(mod_a), 64'd0);
    chk({tag, "_data"}, data_a, 64'd0);
    chk({tag, "_cur"},  64'(cur_a), 64'd0);
    chk({tag, "_pkt"},  64'(pkt_cnt_a), 64'd0);
    chk({tag, "_err"},  64'(err_cnt_a), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; full = 1'b0;
    ch_val = '0; ch_sop = '0; ch_eop = '0; ch_mod = '0; ch_data = '0;

    // IDLE ready decisions with the RR pointer at 0 (identical for both modes)
    vt[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, "rdy_none"};
    vt[1] = '{4'b1111, 4'b1111, 1'b0, 4'b0001, "rdy_all_req"};
    vt[2] = '{4'b1100, 4'b1100, 1'b0, 4'b0100, "rdy_hi_req"};
    vt[3] = '{4'b0110, 4'b0010, 1'b0, 4'b0110, "rdy_orphan_grant"};
    vt[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, "rdy_full"};
    vt[5] = '{4'b1010, 4'b0000, 1'b0, 4'b1010, "rdy_orphans"};
    vt[6] = '{4'b1010, 4'b0000, 1'b1, 4'b0000, "rdy_orphans_full"};
    vt[7] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, "rdy_ch3"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_a("reset_a");
    chk("reset_b_val", 64'(val_b), 64'd0);
    chk("reset_b_data", data_b, 64'd0);
    chk("reset_b_pkt", pkt_cnt_b, 64'd0);

    // Table: held in reset so state stays IDLE while ready is probed
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      ch_val = vt[v].val; ch_sop = vt[v].sop; full = vt[v].full;
      #1;
      chk({vt[v].nm, "_a"}, 64'(rdy_a), 64'(vt[v].rdy));
      chk({vt[v].nm, "_b"}, 64'(rdy_b), 64'(vt[v].rdy));
    end
    ch_val = '0; ch_sop = '0; full = 1'b0;

    // Four simultaneous 3-beat packets: RR order, gap-free
    reset_dut(); use_b = 1'b0; new_meas();
    for (int c = 0; c < N; c++) load_pkt(c, c, 3, 3'd4, 1'b1);
    drive();
    drain(60);
    chk("rr_beats", 64'(n_beats), 64'd12);
    chk("rr_span", 64'(last_cyc - first_cyc), 64'd11);
    for (int c = 0; c < N; c++) chk("rr_pkt_cnt", 64'(pkt_cnt_a[c*4 +: 4]), 64'd1);

    // Locked ch2 under back-pressure with ch0 waiting
    reset_dut(); new_meas();
    load_pkt(2, 20, 5, 3'd2, 1'b1);
    drive();
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin load_pkt(0, 21, 2, 3'd1, 1'b1); drive(); end
      full = (k >= 2 && k <= 4);
      #1;
      if (k == 1) chk("lock_rdy", 64'(rdy_a), 64'(4'b0100));
      if (full) chk("bp_rdy", 64'(rdy_a), 64'd0);
      step();
    end
    full = 1'b0;
    drain(40);
    chk("bp_beats", 64'(n_beats), 64'd7);
    chk("bp_span", 64'(last_cyc - first_cyc), 64'd9);
    chk("bp_pkt_ch2", 64'(pkt_cnt_a[8 +: 4]), 64'd1);
    chk("bp_pkt_ch0", 64'(pkt_cnt_a[0 +: 4]), 64'd1);

    // Fixed priority: ch1 starves ch3
    reset_dut(); use_b = 1'b1; new_meas();
    for (int p = 0; p < 8; p++) begin
      load_pkt(1, 30 + p, 1, 3'd5, 1'b1);
      load_pkt(3, 40 + p, 1, 3'd5, 1'b0);
    end
    drive();
    repeat (8) step();
    src_q[3].delete(); drive();
    drain(20);
    chk("fx_beats", 64'(n_beats), 64'd8);
    chk("fx_pkt_ch1", pkt_cnt_b[16 +: 16], 64'd8);
    chk("fx_pkt_ch3", pkt_cnt_b[48 +: 16], 64'd0);
    use_b = 1'b0;

    // Saturation of a 4-bit packet counter
    reset_dut(); new_meas();
    for (int p = 0; p < 20; p++) load_pkt(0, p, 1, 3'd0, 1'b1);
    drive();
    drain(60);
    chk("sat_beats", 64'(n_beats), 64'd20);
    chk("sat_pkt_ch0", 64'(pkt_cnt_a[0 +: 4]), 64'd15);

    // Orphan beats on ch1 while idle are dropped and counted
    reset_dut(); new_meas();
    begin
      beat_t x;
      x.sop = 1'b0; x.eop = 1'b0; x.mod = 3'd0; x.data = 64'hBAD0_0001;
      src_q[1].push_back(x);
      x.eop = 1'b1; x.data = 64'hBAD0_0002;
      src_q[1].push_back(x);
    end
    drive();
    drain(20);
    chk("orph_err_ch1", 64'(err_cnt_a[4 +: 4]), 64'd2);
    chk("orph_pkt_ch1", 64'(pkt_cnt_a[4 +: 4]), 64'd0);
    chk("orph_beats", 64'(n_beats), 64'd0);

    // Reset on beat 3 of an 8-beat ch3 packet, then a fresh ch0 packet
    new_meas();
    load_pkt(3, 50, 8, 3'd6, 1'b0);
    exp_q.push_back(src_q[3][0]);
    exp_q.push_back(src_q[3][1]);
    drive();
    step(); step();
    chk("mid_cur_ch", 64'(cur_a), 64'd3);
    rst_n = 1'b0;
    step();
    clear_src(); drive();
    @(negedge clk);
    chk_zero_a("midrst");
    chk("midrst_exp_left", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    new_meas();
    load_pkt(0, 60, 2, 3'd3, 1'b1);
    drive();
    drain(20);
    chk("post_rst_beats", 64'(n_beats), 64'd2);
    chk("post_rst_pkt_ch0", 64'(pkt_cnt_a[0 +: 4]), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
